// File: rtl/multi_chn_readout_sched.sv
// Per-channel FIFO readout sequencer: after each EOS, ships every enabled channel's words over SPI in index order.
// Optional SPI_complete watchdog built only when READOUT_TIMEOUT_EN is defined.
module multi_chn_readout_sched #(
  parameter int N_CHN       = 8,
  parameter int CHN_W       = 3,
  parameter int WORDS_W     = 12,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     EOS,
  input  logic [N_CHN-1:0]         chn_mask,
  input  logic [N_CHN*WORDS_W-1:0] chn_words,
  output logic [N_CHN-1:0]         chn_rd_en,
  output logic [CHN_W-1:0]         chn_sel,
  output logic                     spi_start,
  input  logic                     SPI_complete,
  output logic                     ZYNQ_RD_EN,
  output logic                     busy,
  output logic                     done,
  output logic                     eos_overrun,
  output logic                     timeout_err
);

  if ((1 << CHN_W) < N_CHN || N_CHN < 2 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("multi_chn_readout_sched: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_READ, S_SEND, S_WAIT, S_DONE} state_t;

  state_t                            state_q, state_d;
  logic [N_CHN-1:0]                  mask_q, mask_d;
  logic [N_CHN-1:0][WORDS_W-1:0]     cnt_q, cnt_d;
  logic [CHN_W-1:0]                  idx_q, idx_d;
  logic [WORDS_W-1:0]                rem_q, rem_d;
  logic [N_CHN-1:0]                  rd_en_q;
  logic                              start_q, zynq_q, busy_q, done_q, ovr_q;
  logic                              tmo;
  logic                              last_chn, chn_live;

  assign last_chn = (idx_q == CHN_W'(N_CHN - 1));
  assign chn_live = mask_q[idx_q] && (cnt_q[idx_q] != '0);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    unique case (state_q)
      S_IDLE: if (EOS) begin
        mask_d  = chn_mask;
        cnt_d   = chn_words;
        idx_d   = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (chn_live) begin
          rem_d   = cnt_q[idx_q];
          state_d = S_READ;
        end else if (last_chn) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + CHN_W'(1);
        end
      end
      S_READ: state_d = S_SEND;
      S_SEND: state_d = S_WAIT;
      S_WAIT: if (SPI_complete || tmo) begin
        // A timeout drops the rest of the channel and advances as if its last word completed.
        rem_d = SPI_complete ? rem_q - WORDS_W'(1) : '0;
        if (SPI_complete && rem_q != WORDS_W'(1)) begin
          state_d = S_READ;
        end else if (last_chn) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + CHN_W'(1);
          state_d = S_SCAN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up exactly with the state they flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      rd_en_q <= '0;
      start_q <= 1'b0;
      zynq_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      rd_en_q <= (state_d == S_READ) ? (N_CHN'(1) << idx_d) : '0;
      start_q <= (state_d == S_SEND);
      zynq_q  <= (state_d == S_SCAN) || (state_d == S_READ) ||
                 (state_d == S_SEND) || (state_d == S_WAIT);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      ovr_q   <= EOS && (state_q != S_IDLE);
    end
  end

`ifdef READOUT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wdog_q;
  logic            terr_q;

  // Fires on the TIMEOUT_CYC-th WAIT cycle; a same-cycle SPI_complete takes priority.
  assign tmo = (state_q == S_WAIT) && !SPI_complete && (wdog_q == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q <= '0;
      terr_q <= 1'b0;
    end else begin
      if (state_q == S_SEND)      wdog_q <= '0;
      else if (state_q == S_WAIT) wdog_q <= wdog_q + WD_W'(1);
      if (tmo) terr_q <= 1'b1;
    end
  end

  assign timeout_err = terr_q;
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign chn_rd_en   = rd_en_q;
  assign chn_sel     = idx_q;
  assign spi_start   = start_q;
  assign ZYNQ_RD_EN  = zynq_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign eos_overrun = ovr_q;

endmodule
